lsu: RTL

Load/store unit directly downstream of the ALU. For `I_type_ld` (0000011) and `S_type` (0100011) instructions, it takes the ALU's rs1+imm result as the effective address and runs a request/grant/response transaction on the data-memory port. It formats load data (size and sign) for register writeback and raises a single-cycle error on misaligned access or memory timeout. One transaction is in flight at a time; the issue stage stalls on `ready_out`.

---
 rtl/lsu.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory transaction at a time.
// It drives req/gnt/rvalid, formats load data for writeback, and flags misalignment and timeouts.
module lsu #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   output logic              ready_out,
   input  logic [6:0]        opcode_in,
   input  logic [2:0]        funct3,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [31:0]       rs2_value_in,
   input  logic [4:0]        rd_in,
   output logic              mem_req_out,
   output logic              mem_we_out,
   output logic [3:0]        mem_be_out,
   output logic [ADDR_W-1:0] mem_addr_out,
   output logic [31:0]       mem_wdata_out,
   input  logic              mem_gnt_in,
   input  logic              mem_rvalid_in,
   input  logic [31:0]       mem_rdata_in,
   output logic              wb_valid_out,
   output logic [4:0]        wb_rd_out,
   output logic [31:0]       wb_data_out,
   output logic              done_out,
   output logic              err_out,
   output logic [1:0]        err_cause_out
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam int unsigned CNT_W   = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP, RESP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       size_q;
   logic             uns_q;
   logic [1:0]       off_q;
   logic [4:0]       rd_q;
   logic             store_q;
   logic             misal_q;

   logic        is_ls;
   logic        accept;
   logic        misal;
   logic [3:0]  be_c;
   logic [31:0] wdata_c;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign is_ls  = (opcode_in == OP_LOAD) || (opcode_in == OP_STORE);
   assign accept = valid_in && ready_out && is_ls;

   always_comb begin
      misal   = 1'b0;
      be_c    = 4'b1111;
      wdata_c = rs2_value_in;
      unique case (funct3[1:0])
         2'b00: begin
            be_c    = 4'b0001 << addr_in[1:0];
            wdata_c = {4{rs2_value_in[7:0]}};
         end
         2'b01: begin
            misal   = addr_in[0];
            be_c    = 4'b0011 << addr_in[1:0];
            wdata_c = {2{rs2_value_in[15:0]}};
         end
         default: misal = (addr_in[1:0] != 2'b00);
      endcase
   end

   always_comb begin
      ld_byte = mem_rdata_in[{off_q, 3'b000} +: 8];
      ld_half = off_q[1] ? mem_rdata_in[31:16] : mem_rdata_in[15:0];
      unique case (size_q)
         2'b00:   ld_data = uns_q ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
         2'b01:   ld_data = uns_q ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
         default: ld_data = mem_rdata_in;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         ready_out     <= 1'b1;
         mem_req_out   <= 1'b0;
         mem_we_out    <= 1'b0;
         mem_be_out    <= '0;
         mem_addr_out  <= '0;
         mem_wdata_out <= '0;
         wb_valid_out  <= 1'b0;
         wb_rd_out     <= '0;
         wb_data_out   <= '0;
         done_out      <= 1'b0;
         err_out       <= 1'b0;
         err_cause_out <= '0;
         size_q        <= '0;
         uns_q         <= 1'b0;
         off_q         <= '0;
         rd_q          <= '0;
         store_q       <= 1'b0;
         misal_q       <= 1'b0;
      end else begin
         wb_valid_out <= 1'b0;
         done_out     <= 1'b0;
         err_out      <= 1'b0;
         unique case (state)
            IDLE: if (accept) begin
               size_q        <= funct3[1:0];
               uns_q         <= funct3[2];
               off_q         <= addr_in[1:0];
               rd_q          <= rd_in;
               store_q       <= (opcode_in == OP_STORE);
               misal_q       <= misal;
               mem_addr_out  <= {addr_in[ADDR_W-1:2], 2'b00};
               mem_we_out    <= (opcode_in == OP_STORE);
               mem_be_out    <= be_c;
               mem_wdata_out <= wdata_c;
               mem_req_out   <= !misal;
               cnt           <= '0;
               ready_out     <= 1'b0;
               state         <= REQ;
            end
            REQ: begin
               // A misaligned access idles here one cycle with the request masked,
               // so its error lands at the same latency as a granted store.
               if (misal_q) begin
                  err_out       <= 1'b1;
                  err_cause_out <= 2'b01;
                  state         <= RESP;
               end else if (mem_gnt_in) begin
                  mem_req_out <= 1'b0;
                  cnt         <= '0;
                  if (store_q) begin
                     done_out <= 1'b1;
                     state    <= RESP;
                  end else begin
                     state <= WAIT_RESP;
                  end
               end else if (cnt == CNT_MAX) begin
                  mem_req_out   <= 1'b0;
                  err_out       <= 1'b1;
                  err_cause_out <= 2'b10;
                  state         <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            WAIT_RESP: begin
               if (mem_rvalid_in) begin
                  wb_valid_out <= 1'b1;
                  wb_data_out  <= ld_data;
                  wb_rd_out    <= rd_q;
                  state        <= RESP;
               end else if (cnt == CNT_MAX) begin
                  err_out       <= 1'b1;
                  err_cause_out <= 2'b10;
                  state         <= RESP;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            RESP: begin
               ready_out <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
